menu_select_ctrl: RTL and testbench
===================================

MENU_SELECT_CTRL -- requirements
Module: menu_select_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- BTN_X0, 160, left edge of all level buttons (inclusive).
- BTN_X1, 480, right edge of all level buttons (exclusive).
- BTN_Y0, 80, top of level-1 button (inclusive).
- BTN_H, 60, button height.
- BTN_PITCH, 120, vertical distance between consecutive button tops.
- DEB_CYCLES, 16, consecutive stable cycles needed to accept a button change (>=2).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- mouse_x  in  10  cursor x, screen pixels.
- mouse_y  in  10  cursor y, screen pixels.
- mouse_valid  in  1  one-cycle strobe; mouse_x/mouse_y valid this cycle.
- mouse_left  in  1  raw left-button level, asynchronous, 1 = pressed.
- enable  in  1  menu scene active.
- level_ack  in  1  consumer accepts the current selection.
- mouseInLevel1/2/3  out  1 each  registered hover flags for the menu renderer.
- level_valid  out  1  selection pending.
- level_id  out  2  selected level, 1..3; 0 when no selection is pending.

Function
REQ-003 Position regs SHALL load mouse_x/mouse_y on each clk edge where mouse_valid=1 and hold otherwise.
REQ-004 Button k (k=1..3) SHALL be hit when BTN_X0<=x<BTN_X1 and BTN_Y0+(k-1)*BTN_PITCH<=y<BTN_Y0+(k-1)*BTN_PITCH+BTN_H, using the position regs; compares SHALL be unsigned 10-bit with no wrap.
REQ-005 hover_id SHALL be the hit button number, or 0 if no button is hit. At most one button can be hit with the defaults.
REQ-006 mouseInLevelk SHALL be registered as (enable && hover_id==k).
- Latency: mouseInLevelk reflects a mouse_valid sample at the 2nd rising edge after that sample.
REQ-007 mouse_left SHALL pass through a 2-FF synchronizer.
- Debounced level btn_db SHALL take the synchronized value only after that value has differed from btn_db for DEB_CYCLES consecutive cycles.
- Any agreement between the two SHALL clear the counter.
REQ-008 press SHALL be a 1-cycle internal pulse on each btn_db 0->1 change; release SHALL be a 1-cycle internal pulse on each 1->0 change.
REQ-009 The FSM SHALL have three states: IDLE, ARMED, WAIT_ACK. An armed_id register (2 bits) SHALL accompany it.
REQ-010 IDLE: press && enable && hover_id!=0 SHALL move to ARMED and set armed_id=hover_id. Any other press SHALL be ignored, and the FSM stays in IDLE.
REQ-011 ARMED transitions:
- enable=0 SHALL return to IDLE with no selection (enable has priority over release).
- release && hover_id==armed_id SHALL move to WAIT_ACK.
- release with any other hover_id SHALL cancel to IDLE.
REQ-012 On entry to WAIT_ACK, level_valid=1 and level_id=armed_id SHALL both be registered on the same edge.
REQ-013 In WAIT_ACK, level_valid and level_id SHALL hold stable until level_ack=1 is sampled.
- On that edge: FSM goes to IDLE, level_valid=0, level_id=0.
- enable, press and release SHALL be ignored in WAIT_ACK.
REQ-014 level_ack SHALL be ignored whenever level_valid=0.
REQ-015 Mouse motion SHALL never alter armed_id; only the release-time hover_id is compared.
REQ-016 If a press occurs in the same cycle that WAIT_ACK exits, it SHALL be lost. A new selection requires a new press.

Reset
REQ-017 While rst=0, asynchronously:
- FSM=IDLE, armed_id=0, position regs=0.
- Synchronizer FFs=0, btn_db=0, debounce counter=0.
- mouseInLevel1/2/3=0, level_valid=0, level_id=0.
REQ-018 Reset asserted mid-operation (ARMED or WAIT_ACK) SHALL discard the pending selection. No level_valid SHALL appear after rst deasserts until a full new press/release sequence completes.

Verification
REQ-019 Hover: enable=1, mouse_valid with (300,100) -> mouseInLevel1=1 two edges later.
- Then (300,140) -> all flags 0.
- Then (479,379) -> mouseInLevel3=1.
- Then (480,379) -> all flags 0.
REQ-020 Select: cursor (200,220), press held 20 cycles, then released 20 cycles -> level_valid=1 with level_id=2.
- Both hold for 50 cycles with level_ack=0.
- level_ack pulse -> level_valid=0 and level_id=0 on the next edge.
REQ-021 Cancel: press at (200,100), move to (200,220), release -> level_valid stays 0 and the FSM returns to IDLE.
- Also: press at (10,10) -> FSM stays IDLE.
REQ-022 Debounce: mouse_left glitches of 1..DEB_CYCLES-1 cycles over button 1 -> no state change.
- A level held DEB_CYCLES+3 cycles -> accepted.
REQ-023 Enable/ack priority:
- enable=0 in ARMED -> IDLE, all flags 0.
- enable=0 in WAIT_ACK -> level_valid remains 1 until level_ack.
- level_ack=1 while idle -> no effect.
REQ-024 Reset: assert rst=0 during WAIT_ACK (level_id=3) -> all outputs 0 immediately.
- After release of rst, no level_valid appears without a new press and release.

Source files
------------

// File: rtl/menu_select_ctrl_if.sv
// rtl/menu_select_ctrl_if.sv - mouse input and level selection signal bundle for the menu controller
interface menu_select_ctrl_if;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       mouse_valid;
    logic       mouse_left;
    logic       enable;
    logic       level_ack;
    logic       mouseInLevel1;
    logic       mouseInLevel2;
    logic       mouseInLevel3;
    logic       level_valid;
    logic [1:0] level_id;

    modport master (
        output mouse_x, mouse_y, mouse_valid, mouse_left, enable, level_ack,
        input  mouseInLevel1, mouseInLevel2, mouseInLevel3, level_valid, level_id
    );

    modport slave (
        input  mouse_x, mouse_y, mouse_valid, mouse_left, enable, level_ack,
        output mouseInLevel1, mouseInLevel2, mouseInLevel3, level_valid, level_id
    );
endinterface

// File: rtl/menu_select_ctrl.sv
// rtl/menu_select_ctrl.sv - menu level button hover, debounced click and selection handshake
module menu_select_ctrl #(
    parameter int unsigned BTN_X0     = 160,
    parameter int unsigned BTN_X1     = 480,
    parameter int unsigned BTN_Y0     = 80,
    parameter int unsigned BTN_H      = 60,
    parameter int unsigned BTN_PITCH  = 120,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    menu_select_ctrl_if.slave   bus
);
    localparam int CW = $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {IDLE, ARMED, WAIT_ACK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      armed_id_q, armed_id_d;
    logic [9:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic            sync1_q, sync2_q;
    logic            btn_db_q, btn_db_d;
    logic [CW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [2:0]      hov_flags_q, hov_flags_d;
    logic            level_valid_q, level_valid_d;
    logic [1:0]      level_id_q, level_id_d;

    logic [31:0]     px, py;
    logic [1:0]      hover_id;
    logic            flip, press, release_p;

    // Widen to 32 bits so button bounds near the top of the 10-bit range cannot wrap.
    assign px = {22'd0, pos_x_q};
    assign py = {22'd0, pos_y_q};

    always_comb begin
        hover_id = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (px >= BTN_X0 && px < BTN_X1 &&
                py >= BTN_Y0 + (k - 1) * BTN_PITCH &&
                py <  BTN_Y0 + (k - 1) * BTN_PITCH + BTN_H)
                hover_id = 2'(k);
        end
    end

    always_comb begin
        pos_x_d = bus.mouse_valid ? bus.mouse_x : pos_x_q;
        pos_y_d = bus.mouse_valid ? bus.mouse_y : pos_y_q;
        hov_flags_d[0] = bus.enable && (hover_id == 2'd1);
        hov_flags_d[1] = bus.enable && (hover_id == 2'd2);
        hov_flags_d[2] = bus.enable && (hover_id == 2'd3);
    end

    // The counter only advances while the synchronized level disagrees with btn_db.
    always_comb begin
        btn_db_d  = btn_db_q;
        deb_cnt_d = '0;
        flip      = 1'b0;
        if (sync2_q != btn_db_q) begin
            if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
                flip     = 1'b1;
                btn_db_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        press     = flip && !btn_db_q;
        release_p = flip && btn_db_q;
    end

    always_comb begin
        state_d       = state_q;
        armed_id_d    = armed_id_q;
        level_valid_d = level_valid_q;
        level_id_d    = level_id_q;
        case (state_q)
            IDLE: begin
                if (press && bus.enable && hover_id != 2'd0) begin
                    state_d    = ARMED;
                    armed_id_d = hover_id;
                end
            end
            ARMED: begin
                if (!bus.enable) begin
                    state_d    = IDLE;
                    armed_id_d = 2'd0;
                end else if (release_p) begin
                    if (hover_id == armed_id_q) begin
                        state_d       = WAIT_ACK;
                        level_valid_d = 1'b1;
                        level_id_d    = armed_id_q;
                    end else begin
                        state_d    = IDLE;
                        armed_id_d = 2'd0;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.level_ack) begin
                    state_d       = IDLE;
                    armed_id_d    = 2'd0;
                    level_valid_d = 1'b0;
                    level_id_d    = 2'd0;
                end
            end
            default: begin
                state_d       = IDLE;
                armed_id_d    = 2'd0;
                level_valid_d = 1'b0;
                level_id_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            armed_id_q    <= 2'd0;
            pos_x_q       <= 10'd0;
            pos_y_q       <= 10'd0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            deb_cnt_q     <= '0;
            hov_flags_q   <= 3'd0;
            level_valid_q <= 1'b0;
            level_id_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            armed_id_q    <= armed_id_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            sync1_q       <= bus.mouse_left;
            sync2_q       <= sync1_q;
            btn_db_q      <= btn_db_d;
            deb_cnt_q     <= deb_cnt_d;
            hov_flags_q   <= hov_flags_d;
            level_valid_q <= level_valid_d;
            level_id_q    <= level_id_d;
        end
    end

    assign bus.mouseInLevel1 = hov_flags_q[0];
    assign bus.mouseInLevel2 = hov_flags_q[1];
    assign bus.mouseInLevel3 = hov_flags_q[2];
    assign bus.level_valid   = level_valid_q;
    assign bus.level_id      = level_id_q;
endmodule

// File: tb/tb_menu_select_ctrl.sv
// tb/tb_menu_select_ctrl.sv - scoreboard bench for menu_select_ctrl with randomized clicks
module tb_menu_select_ctrl;
    localparam int DEB = 16;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_q[$];

    menu_select_ctrl_if bus ();

    menu_select_ctrl #(
        .BTN_X0(160), .BTN_X1(480), .BTN_Y0(80), .BTN_H(60),
        .BTN_PITCH(120), .DEB_CYCLES(DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: button k spans x in [160,480) and y in [80+120(k-1), 140+120(k-1)).
    function automatic int model_hover(int x, int y);
        int top;
        model_hover = 0;
        for (int k = 1; k <= 3; k++) begin
            top = 80 + (k - 1) * 120;
            if (x >= 160 && x < 480 && y >= top && y < top + 60) model_hover = k;
        end
    endfunction

    function automatic logic [2:0] model_flags(int x, int y, logic en);
        int h;
        h = model_hover(x, y);
        model_flags = 3'd0;
        if (en && h != 0) model_flags[h-1] = 1'b1;
    endfunction

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pos(int x, int y);
        bus.mouse_x     = 10'(x);
        bus.mouse_y     = 10'(y);
        bus.mouse_valid = 1'b1;
        cycles(1);
        bus.mouse_valid = 1'b0;
    endtask

    function automatic int flags_now();
        flags_now = {29'd0, bus.mouseInLevel3, bus.mouseInLevel2, bus.mouseInLevel1};
    endfunction

    task automatic press_release(int x1, int y1, int x2, int y2);
        set_pos(x1, y1);
        cycles(2);
        bus.mouse_left = 1'b1;
        cycles(DEB + 6);
        set_pos(x2, y2);
        cycles(3);
        bus.mouse_left = 1'b0;
        cycles(DEB + 6);
    endtask

    task automatic wait_sel_ack(int exp_id, int hold);
        int t = 0;
        int bad = 0;
        while (!bus.level_valid && t < 100) begin
            cycles(1);
            t++;
        end
        check("sel_seen", int'(bus.level_valid), 1);
        for (int i = 0; i < hold; i++) begin
            cycles(1);
            if (!bus.level_valid || int'(bus.level_id) != exp_id) bad++;
        end
        check("sel_hold_unstable_cycles", bad, 0);
        bus.level_ack = 1'b1;
        cycles(1);
        bus.level_ack = 1'b0;
        check("ack_clears_valid", int'(bus.level_valid), 0);
        check("ack_clears_id", int'(bus.level_id), 0);
    endtask

    function automatic int rand_x();
        int edges[4] = '{159, 160, 479, 480};
        case ($urandom_range(0, 3))
            0:       rand_x = $urandom_range(0, 1023);
            1:       rand_x = edges[$urandom_range(0, 3)];
            default: rand_x = $urandom_range(160, 479);
        endcase
    endfunction

    function automatic int rand_y();
        int edges[12] = '{79, 80, 139, 140, 199, 200, 259, 260, 319, 320, 379, 380};
        case ($urandom_range(0, 3))
            0:       rand_y = $urandom_range(0, 1023);
            1:       rand_y = edges[$urandom_range(0, 11)];
            default: rand_y = 80 + 120 * $urandom_range(0, 2) + $urandom_range(0, 59);
        endcase
    endfunction

    // Monitor: every rising edge of level_valid must match the oldest expected selection.
    initial begin
        logic prev = 1'b0;
        int   e;
        forever begin
            @(negedge clk);
            if (bus.level_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    check("sel_when_none_expected", int'(bus.level_id), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sel_id", int'(bus.level_id), e);
                end
            end
            prev = bus.level_valid;
        end
    end

    initial begin
        int x1, y1, x2, y2, h1, h2;
        logic en;

        rst             = 1'b0;
        bus.mouse_x     = '0;
        bus.mouse_y     = '0;
        bus.mouse_valid = 1'b0;
        bus.mouse_left  = 1'b0;
        bus.enable      = 1'b0;
        bus.level_ack   = 1'b0;
        cycles(3);
        check("reset_flags", flags_now(), 0);
        check("reset_valid", int'(bus.level_valid), 0);
        check("reset_id", int'(bus.level_id), 0);
        rst = 1'b1;
        bus.enable = 1'b1;
        cycles(2);

        // Hover points including right-edge exclusivity and gap between buttons.
        set_pos(300, 100); cycles(1); check("hover_300_100", flags_now(), int'(model_flags(300, 100, 1'b1)));
        set_pos(300, 140); cycles(1); check("hover_300_140", flags_now(), int'(model_flags(300, 140, 1'b1)));
        set_pos(479, 379); cycles(1); check("hover_479_379", flags_now(), int'(model_flags(479, 379, 1'b1)));
        set_pos(480, 379); cycles(1); check("hover_480_379", flags_now(), int'(model_flags(480, 379, 1'b1)));

        for (int i = 0; i < 20; i++) begin
            x1 = rand_x(); y1 = rand_y(); en = 1'($urandom_range(0, 1));
            bus.enable = en;
            set_pos(x1, y1);
            cycles(1);
            check("hover_rand", flags_now(), int'(model_flags(x1, y1, en)));
        end
        bus.enable = 1'b1;

        // Basic selection of level 2 with a long hold before ack.
        exp_q.push_back(2);
        press_release(200, 220, 200, 220);
        wait_sel_ack(2, 50);

        // Cancel by moving off the armed button, and a press outside any button.
        press_release(200, 100, 200, 220);
        check("cancel_no_valid", int'(bus.level_valid), 0);
        press_release(10, 10, 10, 10);
        check("outside_no_valid", int'(bus.level_valid), 0);

        // Short glitches must not register as press or release.
        set_pos(300, 100);
        cycles(2);
        for (int l = 1; l < DEB; l++) begin
            bus.mouse_left = 1'b1; cycles(l);
            bus.mouse_left = 1'b0; cycles(4);
        end
        cycles(DEB + 4);
        check("glitch_high_no_valid", int'(bus.level_valid), 0);
        bus.mouse_left = 1'b1;
        cycles(DEB + 3);
        cycles(4);
        for (int l = 1; l < DEB; l++) begin
            bus.mouse_left = 1'b0; cycles(l);
            bus.mouse_left = 1'b1; cycles(4);
        end
        cycles(DEB + 4);
        check("glitch_low_no_valid", int'(bus.level_valid), 0);
        exp_q.push_back(1);
        bus.mouse_left = 1'b0;
        cycles(DEB + 3);
        wait_sel_ack(1, 3);

        // enable dropped while armed: back to idle, later release does nothing.
        set_pos(300, 100);
        cycles(2);
        bus.mouse_left = 1'b1;
        cycles(DEB + 6);
        bus.enable = 1'b0;
        cycles(2);
        check("armed_disable_flags", flags_now(), 0);
        check("armed_disable_valid", int'(bus.level_valid), 0);
        bus.mouse_left = 1'b0;
        cycles(DEB + 6);
        bus.enable = 1'b1;
        cycles(DEB + 6);
        check("armed_disable_no_sel", int'(bus.level_valid), 0);

        // enable dropped in WAIT_ACK: selection held until ack.
        exp_q.push_back(3);
        press_release(300, 340, 300, 340);
        bus.enable = 1'b0;
        cycles(20);
        check("waitack_disable_valid", int'(bus.level_valid), 1);
        check("waitack_disable_id", int'(bus.level_id), 3);
        wait_sel_ack(3, 2);
        bus.enable = 1'b1;

        // ack while idle has no effect; a normal selection still works afterwards.
        bus.level_ack = 1'b1;
        cycles(3);
        bus.level_ack = 1'b0;
        check("idle_ack_valid", int'(bus.level_valid), 0);
        exp_q.push_back(1);
        press_release(170, 81, 170, 81);
        wait_sel_ack(1, 5);

        // Reset during WAIT_ACK discards the selection.
        exp_q.push_back(3);
        press_release(300, 340, 300, 340);
        cycles(2);
        check("pre_reset_id", int'(bus.level_id), 3);
        rst = 1'b0;
        #1;
        check("reset_mid_valid", int'(bus.level_valid), 0);
        check("reset_mid_id", int'(bus.level_id), 0);
        check("reset_mid_flags", flags_now(), 0);
        cycles(2);
        rst = 1'b1;
        cycles(40);
        check("post_reset_no_valid", int'(bus.level_valid), 0);

        // Randomized press/release pairs against the reference selection rule.
        for (int i = 0; i < 30; i++) begin
            x1 = rand_x(); y1 = rand_y();
            if ($urandom_range(0, 1) == 1) begin
                x2 = x1; y2 = y1;
            end else begin
                x2 = rand_x(); y2 = rand_y();
            end
            h1 = model_hover(x1, y1);
            h2 = model_hover(x2, y2);
            if (h1 != 0 && h1 == h2) begin
                exp_q.push_back(h1);
                press_release(x1, y1, x2, y2);
                wait_sel_ack(h1, $urandom_range(0, 10));
            end else begin
                press_release(x1, y1, x2, y2);
                check("rand_no_sel", int'(bus.level_valid), 0);
            end
        end

        cycles(10);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
